// File: rtl/vga_timing_ctrl_if.sv
// Configuration port of vga_timing_ctrl: valid/ready timing offer plus reject pulse.
interface vga_timing_ctrl_if #(parameter int CW = 11) ();
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_h_active;
  logic [CW-1:0] cfg_h_fp;
  logic [CW-1:0] cfg_h_sync;
  logic [CW-1:0] cfg_h_bp;
  logic [CW-1:0] cfg_v_active;
  logic [CW-1:0] cfg_v_fp;
  logic [CW-1:0] cfg_v_sync;
  logic [CW-1:0] cfg_v_bp;
  logic          cfg_hpol;
  logic          cfg_vpol;
  logic          cfg_err;

  modport master (
    output cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
           cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp, cfg_hpol, cfg_vpol,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA pixel-timing sequencer with frame-boundary config apply.
// Optional VGA_TIMING_CTRL_QUAD_EN adds registered quadrant split outputs.
module vga_timing_ctrl #(
  parameter int CW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  vga_timing_ctrl_if.slave cfg,
  output logic [CW-1:0] px_h,
  output logic [CW-1:0] px_v,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_CTRL_QUAD_EN
  ,
  output logic [CW-1:0] quad_h_split,
  output logic [CW-1:0] quad_v_split
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

  typedef struct packed {
    logic [CW-1:0] ha;
    logic [CW-1:0] hf;
    logic [CW-1:0] hs;
    logic [CW-1:0] hb;
    logic [CW-1:0] va;
    logic [CW-1:0] vf;
    logic [CW-1:0] vs;
    logic [CW-1:0] vb;
    logic          hp;
    logic          vp;
  } tim_t;

  localparam tim_t TIM_RST = '{ha: CW'(640), hf: CW'(16), hs: CW'(96), hb: CW'(48),
                               va: CW'(480), vf: CW'(10), vs: CW'(2),  vb: CW'(33),
                               hp: 1'b0, vp: 1'b0};
  localparam logic [CW+1:0] TMAX = (CW+2)'((1 << CW) - 1);

  state_t        state_q, state_d;
  tim_t          tim_q, shadow_q, shadow_d, tim_n, tim_in;
  logic          pending_q, pending_d;
  logic [CW-1:0] h_q, v_q, h_d, v_d, h_inc, v_inc;
  logic          active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic          ls_q, ls_d, fs_q, fs_d, err_q, err_d;
  logic [CW+1:0] ht_in, vt_in;
  logic [CW:0]   ht_m1, vt_m1, hs_lo, hs_hi, vs_lo, vs_hi;
  logic          cfg_bad, xfer, apply, h_last, v_last, frame_last, run_d, hreg, vreg;

  always_comb begin
    tim_in = '{ha: cfg.cfg_h_active, hf: cfg.cfg_h_fp, hs: cfg.cfg_h_sync, hb: cfg.cfg_h_bp,
               va: cfg.cfg_v_active, vf: cfg.cfg_v_fp, vs: cfg.cfg_v_sync, vb: cfg.cfg_v_bp,
               hp: cfg.cfg_hpol, vp: cfg.cfg_vpol};
    // Two spare bits so four maximal fields cannot wrap back into the legal range
    ht_in = (CW+2)'(tim_in.ha) + (CW+2)'(tim_in.hf) + (CW+2)'(tim_in.hs) + (CW+2)'(tim_in.hb);
    vt_in = (CW+2)'(tim_in.va) + (CW+2)'(tim_in.vf) + (CW+2)'(tim_in.vs) + (CW+2)'(tim_in.vb);
    cfg_bad = (tim_in.ha == '0) || (tim_in.hs == '0) || (tim_in.va == '0) ||
              (tim_in.vs == '0) || (ht_in > TMAX) || (vt_in > TMAX);
    xfer = cfg.cfg_valid && !pending_q;

    ht_m1 = (CW+1)'(tim_q.ha) + (CW+1)'(tim_q.hf) + (CW+1)'(tim_q.hs) + (CW+1)'(tim_q.hb) - 1'b1;
    vt_m1 = (CW+1)'(tim_q.va) + (CW+1)'(tim_q.vf) + (CW+1)'(tim_q.vs) + (CW+1)'(tim_q.vb) - 1'b1;
    h_last = ({1'b0, h_q} == ht_m1);
    v_last = ({1'b0, v_q} == vt_m1);
    frame_last = h_last && v_last;
    h_inc = h_last ? '0 : h_q + 1'b1;
    v_inc = h_last ? (v_last ? '0 : v_q + 1'b1) : v_q;

    apply = pending_q && ((state_q == S_IDLE) || frame_last);
    tim_n = apply ? shadow_q : tim_q;

    state_d = S_IDLE;
    h_d     = '0;
    v_d     = '0;
    run_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_RUN;
          run_d   = 1'b1;
        end
      end
      S_RUN: begin
        state_d = en ? S_RUN : S_STOP;
        h_d     = h_inc;
        v_d     = v_inc;
        run_d   = 1'b1;
      end
      S_STOP: begin
        if (en || !frame_last) begin
          state_d = en ? S_RUN : S_STOP;
          h_d     = h_inc;
          v_d     = v_inc;
          run_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flags are computed from the next counters with the timing that will be live then
    hs_lo = (CW+1)'(tim_n.ha) + (CW+1)'(tim_n.hf);
    hs_hi = hs_lo + (CW+1)'(tim_n.hs);
    vs_lo = (CW+1)'(tim_n.va) + (CW+1)'(tim_n.vf);
    vs_hi = vs_lo + (CW+1)'(tim_n.vs);
    hreg  = run_d && ({1'b0, h_d} >= hs_lo) && ({1'b0, h_d} < hs_hi);
    vreg  = run_d && ({1'b0, v_d} >= vs_lo) && ({1'b0, v_d} < vs_hi);

    active_d = run_d && (h_d < tim_n.ha) && (v_d < tim_n.va);
    hsync_d  = ~(hreg ^ tim_n.hp);
    vsync_d  = ~(vreg ^ tim_n.vp);
    ls_d     = run_d && (h_d == '0);
    fs_d     = ls_d && (v_d == '0);

    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (xfer && !cfg_bad) begin
      shadow_d  = tim_in;
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
    err_d = xfer && cfg_bad;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tim_q     <= TIM_RST;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
      active_q  <= 1'b0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      ls_q      <= 1'b0;
      fs_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef VGA_TIMING_CTRL_QUAD_EN
      quad_h_split <= CW'(320);
      quad_v_split <= CW'(240);
`endif
    end else begin
      state_q   <= state_d;
      tim_q     <= tim_n;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      h_q       <= h_d;
      v_q       <= v_d;
      active_q  <= active_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      ls_q      <= ls_d;
      fs_q      <= fs_d;
      err_q     <= err_d;
`ifdef VGA_TIMING_CTRL_QUAD_EN
      if (apply) begin
        quad_h_split <= shadow_q.ha >> 1;
        quad_v_split <= shadow_q.va >> 1;
      end
`endif
    end
  end

  assign px_h          = h_q;
  assign px_v          = v_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign active        = active_q;
  assign line_start    = ls_q;
  assign frame_start   = fs_q;
  assign cfg.cfg_ready = !pending_q;
  assign cfg.cfg_err   = err_q;

endmodule
